// File: rtl/cntr_cmd_seq.sv
// cntr_cmd_seq: queues load/increment commands and expands them into one-per-cycle ld/inc strobes for a loadable counter.
// Latency: a command accepted into an empty idle sequencer pops on the next edge; its first strobe is visible the cycle after that.
// Backpressure: cmd_ready falls when the DEPTH-entry FIFO is full or rst is high; a same-cycle pop does not raise it.
//
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_data command handshake;
//        ld/inc/data_in registered counter strobes and load value; busy, fifo_count status; sat saturation flag.
// Optional: define CNTR_CMD_SAT_EN to track a shadow of the counter and suppress incs that would wrap it (sat flags this).
module cntr_cmd_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  output logic                     ld,
  output logic                     inc,
  output logic [WIDTH-1:0]         data_in,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     sat
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_INC = 1'b1} state_t;

  // FIFO storage: {op, data}
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic             r_ld;
  logic             r_inc;
  logic [WIDTH-1:0] r_data_in;

  logic             w_push;
  logic             w_pop;
  logic             w_head_op;
  logic [WIDTH-1:0] w_head_dat;
  logic             w_do_ld;
  logic             w_do_inc;
  logic             w_inc_ok;

  assign cmd_ready  = !rst && (r_count != (AW+1)'(DEPTH));
  assign w_push     = cmd_valid && cmd_ready;
  // Only an idle sequencer consumes the head; an increment burst holds the queue.
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_op  = r_mem[r_rd_ptr][WIDTH];
  assign w_head_dat = r_mem[r_rd_ptr][WIDTH-1:0];

  assign w_do_ld    = w_pop && !w_head_op;
  // An increment-by-zero pops without producing any strobe.
  assign w_do_inc   = (w_pop && w_head_op && (w_head_dat != '0)) || (r_state == S_INC);

  // FIFO storage carries no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_data};
    end
  end

  // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Strobe FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_ld      <= 1'b0;
      r_inc     <= 1'b0;
      r_data_in <= '0;
    end else begin
      r_ld  <= w_do_ld;
      r_inc <= w_do_inc && w_inc_ok;
      if (w_do_ld) r_data_in <= w_head_dat;
      case (r_state)
        S_IDLE: begin
          if (w_pop && w_head_op && (w_head_dat != '0)) begin
            // First pulse issues now; r_rem counts the pulses still owed.
            r_rem <= w_head_dat - WIDTH'(1);
            if (w_head_dat > WIDTH'(1)) r_state <= S_INC;
          end
        end
        S_INC: begin
          r_rem <= r_rem - WIDTH'(1);
          if (r_rem == WIDTH'(1)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CNTR_CMD_SAT_EN
  logic [WIDTH-1:0] r_shadow;
  logic             r_sat;

  // Shadow mirrors the downstream counter; an inc from all-ones would wrap it.
  assign w_inc_ok = (r_shadow != '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_sat    <= 1'b0;
    end else if (w_do_ld) begin
      r_shadow <= w_head_dat;
      r_sat    <= 1'b0;
    end else if (w_do_inc) begin
      if (w_inc_ok) r_shadow <= r_shadow + WIDTH'(1);
      else          r_sat    <= 1'b1;
    end
  end

  assign sat = r_sat;
`else
  assign w_inc_ok = 1'b1;
  assign sat      = 1'b0;
`endif

  assign ld         = r_ld;
  assign inc        = r_inc;
  assign data_in    = r_data_in;
  assign fifo_count = r_count;
  assign busy       = (r_count != '0) || (r_state == S_INC);

endmodule

// File: tb/tb_cntr_cmd_seq.sv
// tb_cntr_cmd_seq: directed-vector bench for cntr_cmd_seq (WIDTH=8, DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected strobe sequences are written out by hand in each section.
module tb_cntr_cmd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       ld;
  logic       inc;
  logic [7:0] data_in;
  logic       busy;
  logic [2:0] fifo_count;
  logic       sat;

  int n_chk = 0;
  int n_bad = 0;
  int ev[$];
  bit mon_en = 1'b0;
  int both_hi = 0;
  int last_wait = 0;

  cntr_cmd_seq #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .ld(ld), .inc(inc), .data_in(data_in),
    .busy(busy), .fifo_count(fifo_count), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, then lets one edge capture the command.
  task automatic push(input logic op, input logic [7:0] d);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && w < 100) begin
      tick();
      w++;
    end
    last_wait = w;
    if (!cmd_ready) chk("push_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Event log: ld logs the loaded value, inc logs 256.
  always @(posedge clk) begin
    #1;
    if (ld && inc) both_hi++;
    if (mon_en) begin
      if (ld)  ev.push_back(int'(data_in));
      if (inc) ev.push_back(256);
    end
  end

  initial begin
    int n;
    int exp_q[$];

    // 1. Reset
    tick();
    tick();
    chk("rst_ld", ld, 0);
    chk("rst_inc", inc, 0);
    chk("rst_data", data_in, 0);
    chk("rst_sat", sat, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // 2. Load 0xA5: queued after edge k, ld visible for one cycle after k+1
    push(1'b0, 8'hA5);
    chk("ld_q_cnt", fifo_count, 1);
    chk("ld_not_yet", ld, 0);
    tick();
    chk("ld_pulse", ld, 1);
    chk("ld_data", data_in, 8'hA5);
    chk("ld_popped", fifo_count, 0);
    tick();
    chk("ld_drop", ld, 0);
    chk("ld_hold", data_in, 8'hA5);
    chk("ld_busy", busy, 0);

    // 3. Increment by 3, then by 0
    ev.delete();
    mon_en = 1'b1;
    push(1'b1, 8'd3);
    tick();
    chk("inc3_first", inc, 1);
    chk("inc3_busy", busy, 1);
    repeat (6) tick();
    mon_en = 1'b0;
    exp_q = '{256, 256, 256};
    chk("inc3_len", ev.size(), exp_q.size());
    for (int i = 0; i < ev.size() && i < exp_q.size(); i++) chk("inc3_ev", ev[i], exp_q[i]);
    chk("inc3_idle", busy, 0);

    push(1'b1, 8'd0);
    chk("inc0_q", fifo_count, 1);
    tick();
    chk("inc0_cnt", fifo_count, 0);
    chk("inc0_inc", inc, 0);
    chk("inc0_ld", ld, 0);
    tick();
    chk("inc0_inc2", inc, 0);
    chk("inc0_busy", busy, 0);

    // 4. Fill the FIFO behind a 20-increment burst
    ev.delete();
    mon_en = 1'b1;
    push(1'b1, 8'd20);
    push(1'b0, 8'h11);
    push(1'b1, 8'd2);
    push(1'b0, 8'h22);
    push(1'b1, 8'd1);
    chk("full_cnt", fifo_count, 4);
    chk("full_ready", cmd_ready, 0);
    // Burst incs at edges k+1..k+20, first pop at k+21; we are just past k+4.
    push(1'b0, 8'h33);
    chk("full_wait", last_wait, 17);
    repeat (15) tick();
    mon_en = 1'b0;
    exp_q.delete();
    repeat (20) exp_q.push_back(256);
    exp_q.push_back(8'h11);
    exp_q.push_back(256);
    exp_q.push_back(256);
    exp_q.push_back(8'h22);
    exp_q.push_back(256);
    exp_q.push_back(8'h33);
    chk("full_len", ev.size(), exp_q.size());
    for (int i = 0; i < ev.size() && i < exp_q.size(); i++) chk("full_ev", ev[i], exp_q[i]);
    chk("full_drain", fifo_count, 0);
    chk("full_idle", busy, 0);

    // 5. Reset in the middle of a 10-increment burst
    push(1'b1, 8'd10);
    n = 0;
    repeat (4) begin
      tick();
      if (inc) n++;
    end
    chk("rmid_pulses", n, 4);
    rst = 1'b1;
    #1;
    chk("rmid_ready", cmd_ready, 0);
    tick();
    chk("rmid_inc", inc, 0);
    chk("rmid_cnt", fifo_count, 0);
    rst = 1'b0;
    ev.delete();
    mon_en = 1'b1;
    repeat (15) tick();
    mon_en = 1'b0;
    chk("rmid_quiet", ev.size(), 0);
    chk("rmid_busy", busy, 0);

    // 6. Load 0xFD then increment by 5
    ev.delete();
    mon_en = 1'b1;
    push(1'b0, 8'hFD);
    push(1'b1, 8'd5);
    repeat (12) tick();
    mon_en = 1'b0;
    n = 0;
    foreach (ev[i]) if (ev[i] == 256) n++;
`ifdef CNTR_CMD_SAT_EN
    chk("sat_pulses", n, 2);
    chk("sat_flag", sat, 1);
`else
    chk("sat_pulses", n, 5);
    chk("sat_flag", sat, 0);
`endif
    push(1'b0, 8'h00);
    tick();
    tick();
    chk("sat_clear", sat, 0);
    chk("sat_ld_data", data_in, 8'h00);

    chk("ld_inc_exclusive", both_hi, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cntr_cmd_seq.md
Name: cntr_cmd_seq

Overview:
Command sequencer that sits directly upstream of the 8-bit loadable counter and drives its ld/inc/data_in inputs. It accepts queued commands over a valid/ready handshake: "load value" or "increment by N". It expands each command into single-cycle ld or inc strobes, one strobe per clock. This frees upstream logic from cycle-by-cycle strobe timing.

Parameters:
WIDTH, 8, data width of load value, increment count and data_in output
DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present on cmd_op/cmd_data
cmd_ready  output  1  FIFO can accept a command this cycle
cmd_op  input  1  0 = load cmd_data, 1 = increment cmd_data times
cmd_data  input  WIDTH  load value or increment count N
ld  output  1  counter load strobe, registered
inc  output  1  counter increment strobe, registered
data_in  output  WIDTH  counter load value, registered
busy  output  1  high while FIFO non-empty or an increment burst is in progress
fifo_count  output  $clog2(DEPTH)+1  number of queued commands
sat  output  1  saturation flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge):
  - ld=0, inc=0, data_in=0, sat=0, fifo_count=0; FIFO pointers cleared; state=IDLE; remaining count=0.
  - cmd_ready=0 while rst=1; cmd_ready=1 on the first cycle after rst deasserts.
  - Reset overrides everything. A burst in progress is abandoned; strobes are 0 from the next cycle on.
- Handshake:
  - cmd_ready = !rst && fifo_count != DEPTH.
  - A command is written when cmd_valid && cmd_ready at posedge.
  - No pass-through when full: a pop in the same cycle does not raise ready.
  - Simultaneous push and pop when not full: fifo_count is unchanged.
- FSM states IDLE and INC:
  - IDLE, FIFO empty: ld<=0, inc<=0, stay IDLE.
  - IDLE, head op=0 (load): pop; ld<=1, data_in<=data, inc<=0; stay IDLE. Back-to-back loads produce one ld per cycle.
  - IDLE, head op=1, N>=1: pop; inc<=1, ld<=0, rem<=N-1; go to INC if N>1, else stay IDLE.
  - IDLE, head op=1, N=0: pop with no strobe (ld=inc=0 that cycle); stay IDLE.
  - INC: no pop; inc<=1, rem<=rem-1; go to IDLE when rem==1.
  - An N-increment command produces exactly N consecutive inc cycles. The next command pops on the cycle the last inc is registered.
- Latency:
  - Command accepted at edge k into an empty, idle sequencer is popped at edge k+1.
  - Its first strobe is high in the cycle following edge k+1.
- Invariants:
  - ld and inc are never both 1.
  - data_in holds its last loaded value when ld=0.
  - busy = (fifo_count!=0) || (state==INC).
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - N=2^WIDTH-1 (255) produces 255 pulses with no overflow of rem.

Optional Feature:
Macro CNTR_CMD_SAT_EN.
- Defined:
  - The sequencer keeps a WIDTH-bit shadow of the counter value. The shadow is set on each ld issued and incremented on each inc issued.
  - An inc that would take the shadow past 2^WIDTH-1 is suppressed (inc stays 0) but still consumes its cycle and rem decrement.
  - The first suppression sets sat=1. sat is sticky until the next issued ld or reset.
  - Shadow resets to 0.
- Not defined:
  - No shadow register; all inc strobes are issued and the downstream counter wraps naturally.
  - sat is tied to 0.

Test Plan:
1. Reset: hold rst=1 two cycles -> ld=0, inc=0, data_in=0, sat=0, fifo_count=0, busy=0; cmd_ready=1 the cycle after rst falls.
2. Load: push op=0, data=0xA5 at edge k -> ld=1, data_in=0xA5 for exactly one cycle after edge k+1; then ld=0 with data_in held at 0xA5.
3. Increment: push op=1, N=3 -> exactly 3 consecutive inc cycles with busy=1, then busy=0. Push op=1, N=0 -> no strobe, fifo_count returns to 0.
4. Full: with downstream mid-burst (op=1, N=20), push 4 more commands -> fifo_count=4 and cmd_ready=0. A 5th valid command held high is not accepted until the first pop. All queued commands issue in order.
5. Reset mid-burst: push op=1, N=10; assert rst after 4 inc pulses -> inc=0 from the next cycle; fifo_count=0; no further strobes after rst falls.
6. CNTR_CMD_SAT_EN defined: load 0xFD, then inc N=5 -> 2 inc pulses and 3 suppressed cycles; sat=1 after the first suppression; a subsequent load of 0x00 clears sat. Without the macro, the same stimulus gives 5 inc pulses and sat=0.
